// File: rtl/alu_writeback_if.sv
// Bus bundle between the ALU / load unit / operand fetch and the writeback block.
interface alu_writeback_if #(
    parameter int unsigned DATA_LEN     = 16,
    parameter int unsigned REG_ADDR_LEN = 3
);
    logic                    alu_valid;
    logic                    alu_ready;
    logic [DATA_LEN-1:0]     alu_out;
    logic                    alu_z;
    logic                    alu_z_en;
    logic [REG_ADDR_LEN-1:0] alu_dest;
    logic                    ld_valid;
    logic [REG_ADDR_LEN-1:0] ld_dest;
    logic [DATA_LEN-1:0]     ld_data;
    logic [REG_ADDR_LEN-1:0] rd_addr_a;
    logic [DATA_LEN-1:0]     rd_data_a;
    logic [REG_ADDR_LEN-1:0] rd_addr_b;
    logic [DATA_LEN-1:0]     rd_data_b;
    logic                    hazard_a;
    logic                    hazard_b;
    logic                    z_flag_q;
    logic                    pending;

    modport master (
        output alu_valid, alu_out, alu_z, alu_z_en, alu_dest,
        output ld_valid, ld_dest, ld_data, rd_addr_a, rd_addr_b,
        input  alu_ready, rd_data_a, rd_data_b, hazard_a, hazard_b, z_flag_q, pending
    );

    modport slave (
        input  alu_valid, alu_out, alu_z, alu_z_en, alu_dest,
        input  ld_valid, ld_dest, ld_data, rd_addr_a, rd_addr_b,
        output alu_ready, rd_data_a, rd_data_b, hazard_a, hazard_b, z_flag_q, pending
    );
endinterface

// File: rtl/alu_writeback.sv
// ALU writeback: queues ALU results in a small FIFO and retires one per cycle into the
// register file; memory loads take the write port first. Holds the zero flag and reports
// read-after-write hazards against queued destinations.
module alu_writeback #(
    parameter int unsigned DATA_LEN     = 16,
    parameter int unsigned REG_ADDR_LEN = 3,
    parameter int unsigned DEPTH        = 4
) (
    input logic            clk,
    input logic            reset,
    alu_writeback_if.slave bus
);
    localparam int unsigned PTR_W     = $clog2(DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam int unsigned REG_COUNT = 2 ** REG_ADDR_LEN;

    logic [DATA_LEN-1:0]     regs_q      [REG_COUNT];
    logic [DATA_LEN-1:0]     fifo_data_q [DEPTH];
    logic                    fifo_z_q    [DEPTH];
    logic                    fifo_zen_q  [DEPTH];
    logic [REG_ADDR_LEN-1:0] fifo_dest_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ready_q, ready_d;
    logic             pending_q, pending_d;
    logic             z_q;
    logic             push;
    logic             drain;

    // Handshake decode and next pointer/count state; ready looks only at occupancy.
    always_comb begin
        push    = bus.alu_valid && ready_q;
        drain   = (count_q != '0) && !bus.ld_valid;
        head_d  = drain ? head_q + PTR_W'(1) : head_q;
        tail_d  = push  ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q;
        if (push && !drain) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && drain) begin
            count_d = count_q - CNT_W'(1);
        end
        ready_d   = (count_d != CNT_W'(DEPTH));
        pending_d = (count_d != '0);
    end

    // FIFO storage, register file writes (load first, else retire head) and zero flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_z_q[i]    <= 1'b0;
                fifo_zen_q[i]  <= 1'b0;
                fifo_dest_q[i] <= '0;
            end
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            ready_q   <= 1'b1;
            pending_q <= 1'b0;
            z_q       <= 1'b0;
        end else begin
            if (push) begin
                fifo_data_q[tail_q] <= bus.alu_out;
                fifo_z_q[tail_q]    <= bus.alu_z;
                fifo_zen_q[tail_q]  <= bus.alu_z_en;
                fifo_dest_q[tail_q] <= bus.alu_dest;
            end
            if (bus.ld_valid) begin
                regs_q[bus.ld_dest] <= bus.ld_data;
            end else if (drain) begin
                regs_q[fifo_dest_q[head_q]] <= fifo_data_q[head_q];
                if (fifo_zen_q[head_q]) begin
                    z_q <= fifo_z_q[head_q];
                end
            end
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            ready_q   <= ready_d;
            pending_q <= pending_d;
        end
    end

    // Hazard scan: a slot is live when its distance from head is below the occupancy.
    always_comb begin
        logic [PTR_W-1:0] off;
        off          = '0;
        bus.hazard_a = 1'b0;
        bus.hazard_b = 1'b0;
        for (int unsigned s = 0; s < DEPTH; s++) begin
            off = PTR_W'(s) - head_q;
            if ({1'b0, off} < count_q) begin
                if (fifo_dest_q[s] == bus.rd_addr_a) begin
                    bus.hazard_a = 1'b1;
                end
                if (fifo_dest_q[s] == bus.rd_addr_b) begin
                    bus.hazard_b = 1'b1;
                end
            end
        end
    end

    // Read ports (no bypass) and registered status outputs.
    always_comb begin
        bus.rd_data_a = regs_q[bus.rd_addr_a];
        bus.rd_data_b = regs_q[bus.rd_addr_b];
        bus.alu_ready = ready_q;
        bus.pending   = pending_q;
        bus.z_flag_q  = z_q;
    end
endmodule

// File: tb/tb_alu_writeback.sv
// Directed per-cycle vector bench for alu_writeback. Each row drives inputs at the falling
// edge; its expectations describe the state left by the previous rising edge, observed with
// this row's read addresses, before this row's own rising edge.
module tb_alu_writeback;
    logic clk;
    logic reset;

    alu_writeback_if #(.DATA_LEN(16), .REG_ADDR_LEN(3)) bus_if ();

    alu_writeback #(.DATA_LEN(16), .REG_ADDR_LEN(3), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          chk;
        bit          rst_n;
        bit          av;
        logic [15:0] ao;
        bit          az;
        bit          aze;
        logic [2:0]  ad;
        bit          lv;
        logic [2:0]  ldst;
        logic [15:0] ldat;
        logic [2:0]  ra;
        logic [2:0]  rb;
        bit          rdy;
        bit          pnd;
        bit          zf;
        logic [15:0] da;
        logic [15:0] db;
        bit          ha;
        bit          hb;
    } vec_t;

    vec_t vecs[$];
    int   tests  = 0;
    int   failed = 0;

    task automatic add(input bit chk, input bit rst_n, input bit av, input logic [15:0] ao,
                       input bit az, input bit aze, input logic [2:0] ad, input bit lv,
                       input logic [2:0] ldst, input logic [15:0] ldat, input logic [2:0] ra,
                       input logic [2:0] rb, input bit rdy, input bit pnd, input bit zf,
                       input logic [15:0] da, input logic [15:0] db, input bit ha, input bit hb);
        vec_t v;
        v.chk = chk; v.rst_n = rst_n; v.av = av; v.ao = ao; v.az = az; v.aze = aze; v.ad = ad;
        v.lv = lv; v.ldst = ldst; v.ldat = ldat; v.ra = ra; v.rb = rb;
        v.rdy = rdy; v.pnd = pnd; v.zf = zf; v.da = da; v.db = db; v.ha = ha; v.hb = hb;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int row, input logic [15:0] act,
                         input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL row %0d %s: got %h expected %h", row, name, act, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        bus_if.alu_valid = 1'b0; bus_if.alu_out = '0; bus_if.alu_z = 1'b0;
        bus_if.alu_z_en = 1'b0; bus_if.alu_dest = '0; bus_if.ld_valid = 1'b0;
        bus_if.ld_dest = '0; bus_if.ld_data = '0; bus_if.rd_addr_a = '0; bus_if.rd_addr_b = '0;

        //   chk rst av ao       az aze ad lv ld ldat      ra rb rdy pnd zf da        db        ha hb
        // reset with an offered push that must be discarded
        add(0, 0, 1, 16'hFFFF, 1, 1, 1, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
        add(1, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0);
        // single retire, hazard visible while queued
        add(1, 1, 1, 16'h1234, 0, 1, 3, 0, 0, 16'h0000, 3, 3, 1, 0, 0, 16'h0000, 16'h0000, 0, 0);
        add(1, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 3, 0, 1, 1, 0, 16'h0000, 16'h0000, 1, 0);
        add(1, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 3, 1, 1, 0, 0, 16'h1234, 16'h0000, 0, 0);
        // fill while loads hold the write port; fifth offer refused; then in-order drain
        add(1, 1, 1, 16'hA001, 0, 0, 4, 1, 7, 16'h0777, 4, 7, 1, 0, 0, 16'h0000, 16'h0000, 0, 0);
        add(1, 1, 1, 16'hA002, 0, 0, 5, 1, 7, 16'h0777, 4, 5, 1, 1, 0, 16'h0000, 16'h0000, 1, 0);
        add(1, 1, 1, 16'hA003, 0, 0, 6, 1, 7, 16'h0777, 5, 6, 1, 1, 0, 16'h0000, 16'h0000, 1, 0);
        add(1, 1, 1, 16'hA004, 0, 0, 0, 1, 7, 16'h0777, 6, 0, 1, 1, 0, 16'h0000, 16'h0000, 1, 0);
        add(1, 1, 1, 16'hBAD5, 0, 0, 1, 1, 7, 16'h0777, 0, 1, 0, 1, 0, 16'h0000, 16'h0000, 1, 0);
        add(1, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 4, 7, 0, 1, 0, 16'h0000, 16'h0777, 1, 0);
        add(1, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 4, 5, 1, 1, 0, 16'hA001, 16'h0000, 0, 1);
        add(1, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 5, 6, 1, 1, 0, 16'hA002, 16'h0000, 0, 1);
        add(1, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 6, 0, 1, 1, 0, 16'hA003, 16'h0000, 0, 1);
        add(1, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 0, 1, 1, 0, 0, 16'hA004, 16'h0000, 0, 0);
        // load beats queued write to the same register, queued write lands next edge
        add(1, 1, 1, 16'h0005, 0, 0, 2, 0, 0, 16'h0000, 2, 2, 1, 0, 0, 16'h0000, 16'h0000, 0, 0);
        add(1, 1, 0, 16'h0000, 0, 0, 0, 1, 2, 16'h0009, 2, 0, 1, 1, 0, 16'h0000, 16'hA004, 1, 0);
        add(1, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 2, 3, 1, 1, 0, 16'h0009, 16'h1234, 1, 0);
        add(1, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 2, 1, 1, 0, 0, 16'h0005, 16'h0000, 0, 0);
        // zero flag: set by z_en entry, untouched by following non-z_en entry
        add(1, 1, 1, 16'h0000, 1, 1, 1, 0, 0, 16'h0000, 1, 2, 1, 0, 0, 16'h0000, 16'h0005, 0, 0);
        add(1, 1, 1, 16'h00FF, 0, 0, 2, 0, 0, 16'h0000, 1, 2, 1, 1, 0, 16'h0000, 16'h0005, 1, 0);
        add(1, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 1, 2, 1, 1, 1, 16'h0000, 16'h0005, 0, 1);
        add(1, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 1, 2, 1, 0, 1, 16'h0000, 16'h00FF, 0, 0);
        // full FIFO with drain in the same edge: push refused, count drops to 3
        add(1, 1, 1, 16'hC001, 0, 0, 3, 1, 6, 16'h0066, 3, 6, 1, 0, 1, 16'h1234, 16'hA003, 0, 0);
        add(1, 1, 1, 16'hC002, 0, 0, 4, 1, 6, 16'h0066, 4, 3, 1, 1, 1, 16'hA001, 16'h1234, 0, 1);
        add(1, 1, 1, 16'hC003, 0, 0, 5, 1, 6, 16'h0066, 5, 6, 1, 1, 1, 16'hA002, 16'h0066, 0, 0);
        add(1, 1, 1, 16'hC004, 0, 0, 6, 1, 6, 16'h0066, 6, 4, 1, 1, 1, 16'h0066, 16'hA001, 0, 1);
        add(1, 1, 1, 16'hDEAD, 0, 0, 7, 0, 0, 16'h0000, 7, 6, 0, 1, 1, 16'h0777, 16'h0066, 0, 1);
        add(1, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 3, 7, 1, 1, 1, 16'hC001, 16'h0777, 0, 0);
        add(1, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 4, 5, 1, 1, 1, 16'hC002, 16'hA002, 0, 1);
        add(1, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 5, 6, 1, 1, 1, 16'hC003, 16'h0066, 0, 1);
        add(1, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 6, 7, 1, 0, 1, 16'hC004, 16'h0777, 0, 0);
        // mid-operation reset drops the queued entry and clears everything
        add(1, 1, 1, 16'h1111, 0, 0, 1, 0, 0, 16'h0000, 6, 0, 1, 0, 1, 16'hC004, 16'hA004, 0, 0);
        add(1, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 1, 1, 1, 16'h0000, 16'hA004, 1, 0);
        add(1, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 1, 6, 1, 0, 0, 16'h0000, 16'h0000, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset            = vecs[i].rst_n;
            bus_if.alu_valid = vecs[i].av;
            bus_if.alu_out   = vecs[i].ao;
            bus_if.alu_z     = vecs[i].az;
            bus_if.alu_z_en  = vecs[i].aze;
            bus_if.alu_dest  = vecs[i].ad;
            bus_if.ld_valid  = vecs[i].lv;
            bus_if.ld_dest   = vecs[i].ldst;
            bus_if.ld_data   = vecs[i].ldat;
            bus_if.rd_addr_a = vecs[i].ra;
            bus_if.rd_addr_b = vecs[i].rb;
            #1;
            if (vecs[i].chk) begin
                check("alu_ready", i, 16'(bus_if.alu_ready), 16'(vecs[i].rdy));
                check("pending",   i, 16'(bus_if.pending),   16'(vecs[i].pnd));
                check("z_flag_q",  i, 16'(bus_if.z_flag_q),  16'(vecs[i].zf));
                check("rd_data_a", i, bus_if.rd_data_a,      vecs[i].da);
                check("rd_data_b", i, bus_if.rd_data_b,      vecs[i].db);
                check("hazard_a",  i, 16'(bus_if.hazard_a),  16'(vecs[i].ha));
                check("hazard_b",  i, 16'(bus_if.hazard_b),  16'(vecs[i].hb));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
